// File: rtl/dom_indep_mul_gf2n_pipe.sv
// DOM-indep masked multiplier over GF(2^N) for any number of shares.
// Stage 1 registers every inner product X_i*Y_i and every masked cross
// product X_i*Y_j ^ Z_k in its own register. Stage 2 XOR-compresses the
// registered terms into output shares, optionally followed by one output register.
// Valid semantics: InValidxSI marks the operands sampled on an enabled edge as an
// item; OutValidxSO marks _QxDO as carrying that item's result. There is no
// backpressure: EnxSI=0 freezes the whole pipeline and drops any inputs offered.

// Field multiplier in polynomial basis, reduced by a fixed irreducible polynomial
// per width (N = 2..8): x^2+x+1, x^3+x+1, x^4+x+1, x^5+x^2+1, x^6+x+1,
// x^7+x+1, x^8+x^4+x^3+x+1.
module gf2_mul #(
   parameter int N = 2
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] q
);
   localparam logic [8:0] POLY_FULL = (N == 2) ? 9'h007 :
                                      (N == 3) ? 9'h00B :
                                      (N == 4) ? 9'h013 :
                                      (N == 5) ? 9'h025 :
                                      (N == 6) ? 9'h043 :
                                      (N == 7) ? 9'h083 : 9'h11B;
   localparam logic [N-1:0] POLY = POLY_FULL[N-1:0];

   logic [N-1:0] acc;
   logic [N-1:0] sh;

   // Shift-and-add multiply; the shifted operand is reduced on every step.
   always_comb begin
      acc = '0;
      sh  = a;
      for (int i = 0; i < N; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = sh[N-1] ? ((sh << 1) ^ POLY) : (sh << 1);
      end
      q = acc;
   end
endmodule

module dom_indep_mul_gf2n_pipe #(
   parameter int N       = 2,
   parameter int SHARES  = 2,
   parameter int OUT_REG = 0
) (
   input  logic                                ClkxCI,
   input  logic                                RstxBI,
   input  logic                                EnxSI,
   input  logic                                InValidxSI,
   input  logic [N*SHARES-1:0]                 _XxDI,
   input  logic [N*SHARES-1:0]                 _YxDI,
   input  logic [N*SHARES*(SHARES-1)/2-1:0]    _ZxDI,
   output logic [N*SHARES-1:0]                 _QxDO,
   output logic                                OutValidxSO,
   output logic                                BusyxSO
);
   localparam int DEPTH = 1 + OUT_REG;

   // Index of the fresh mask shared by pair (i,j), i<j, enumerated row by row.
   function automatic int pair_idx(input int i, input int j);
      return i*SHARES - (i*(i+1))/2 + (j-i-1);
   endfunction

   logic [N-1:0]          prod   [SHARES][SHARES];
   logic [N-1:0]          term_d [SHARES][SHARES];
   logic [N-1:0]          term_q [SHARES][SHARES];
   logic [N*SHARES-1:0]   q_sum;
   logic [DEPTH-1:0]      vld_q;

   // All share-domain products; cross terms are masked before the register so
   // no two shares of the same operand ever meet in unregistered logic.
   for (genvar gi = 0; gi < SHARES; gi++) begin : g_row
      for (genvar gj = 0; gj < SHARES; gj++) begin : g_col
         gf2_mul #(.N(N)) u_mul (
            .a (_XxDI[gi*N +: N]),
            .b (_YxDI[gj*N +: N]),
            .q (prod[gi][gj])
         );
         if (gi == gj) begin : g_inner
            assign term_d[gi][gj] = prod[gi][gj];
         end else begin : g_cross
            localparam int K = (gi < gj) ? pair_idx(gi, gj) : pair_idx(gj, gi);
            assign term_d[gi][gj] = prod[gi][gj] ^ _ZxDI[K*N +: N];
         end
      end
   end

   // Stage-1 term registers; they load on every enabled cycle, valid or not.
   always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
         for (int i = 0; i < SHARES; i++)
            for (int j = 0; j < SHARES; j++)
               term_q[i][j] <= '0;
      end else if (EnxSI) begin
         for (int i = 0; i < SHARES; i++)
            for (int j = 0; j < SHARES; j++)
               term_q[i][j] <= term_d[i][j];
      end
   end

   // Stage-2 compression: each output share XORs only its own registered row.
   always_comb begin
      q_sum = '0;
      for (int i = 0; i < SHARES; i++)
         for (int j = 0; j < SHARES; j++)
            q_sum[i*N +: N] = q_sum[i*N +: N] ^ term_q[i][j];
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic [N*SHARES-1:0] q_q;
      // Optional output register, frozen together with the rest of the pipe.
      always_ff @(posedge ClkxCI or negedge RstxBI) begin
         if (!RstxBI)    q_q <= '0;
         else if (EnxSI) q_q <= q_sum;
      end
      assign _QxDO = q_q;
   end else begin : g_out_comb
      assign _QxDO = q_sum;
   end

   // Valid chain shadows the data pipeline depth.
   always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
         vld_q <= '0;
      end else if (EnxSI) begin
         vld_q[0] <= InValidxSI;
         for (int d = 1; d < DEPTH; d++)
            vld_q[d] <= vld_q[d-1];
      end
   end

   assign OutValidxSO = vld_q[DEPTH-1];
   assign BusyxSO     = |vld_q;
endmodule

// File: tb/tb_dom_indep_mul_gf2n_pipe.sv
// Bench for dom_indep_mul_gf2n_pipe: a default instance (N=2, S=2, no output
// register) and an N=4, S=3 instance with output register, on a shared clock,
// reset and enable. Expected products come from hand tables and a reference
// multiplier; a scoreboard tracks order and latency in enabled cycles.
module tb_dom_indep_mul_gf2n_pipe;
   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   logic en;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic        v0, ov0, b0;
   logic [3:0]  x0, y0, q0;
   logic [1:0]  z0;
   logic        v1, ov1, b1;
   logic [11:0] x1, y1, z1, q1;

   dom_indep_mul_gf2n_pipe u_dut0 (
      .ClkxCI(clk), .RstxBI(rst_n), .EnxSI(en), .InValidxSI(v0),
      ._XxDI(x0), ._YxDI(y0), ._ZxDI(z0),
      ._QxDO(q0), .OutValidxSO(ov0), .BusyxSO(b0)
   );

   dom_indep_mul_gf2n_pipe #(.N(4), .SHARES(3), .OUT_REG(1)) u_dut1 (
      .ClkxCI(clk), .RstxBI(rst_n), .EnxSI(en), .InValidxSI(v1),
      ._XxDI(x1), ._YxDI(y1), ._ZxDI(z1),
      ._QxDO(q1), .OutValidxSO(ov1), .BusyxSO(b1)
   );

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: carry-less product, then reduce from the top bit down.
   function automatic logic [7:0] ref_mul(input int n, input logic [8:0] poly,
                                          input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < n; i++)
         if (b[i]) p = p ^ (16'(a) << i);
      for (int k = 2*n-2; k >= n; k--)
         if (p[k]) p = p ^ (16'(poly) << (k-n));
      return p[7:0];
   endfunction

   function automatic int pidx(input int i, input int j);
      return (i == 0) ? j-1 : 2;
   endfunction

   // Expected individual output share i of the 3-share instance.
   function automatic logic [3:0] exp_share1(input int i, input logic [11:0] x,
                                             input logic [11:0] y, input logic [11:0] z);
      logic [7:0] r;
      int k;
      r = ref_mul(4, 9'h13, 8'(x[i*4 +: 4]), 8'(y[i*4 +: 4]));
      for (int j = 0; j < 3; j++) begin
         if (j != i) begin
            k = (i < j) ? pidx(i, j) : pidx(j, i);
            r = r ^ ref_mul(4, 9'h13, 8'(x[i*4 +: 4]), 8'(y[j*4 +: 4])) ^ 8'(z[k*4 +: 4]);
         end
      end
      return r[3:0];
   endfunction

   // ---------------- scoreboard ----------------
   logic [1:0] exp0_in;
   logic [3:0] exp1_in;
   logic [1:0] exp0_q[$];
   logic [3:0] exp1_q[$];
   int         t0_q[$];
   int         t1_q[$];
   int         ecnt = 0;
   logic       en_q = 1'b0;
   logic [3:0] last_exp1 = '0;

   // Capture items on each enabled edge, stamped with the enabled-cycle index.
   always @(posedge clk) begin
      en_q = en;
      if (rst_n && en) begin
         if (v0) begin exp0_q.push_back(exp0_in); t0_q.push_back(ecnt); end
         if (v1) begin exp1_q.push_back(exp1_in); t1_q.push_back(ecnt); end
         ecnt++;
      end
   end

   // Compare each fresh output (after an enabled edge) with the queue head.
   always @(negedge clk) begin
      if (rst_n && en_q) begin
         if (ov0) begin
            if (exp0_q.size() == 0) chk("ov0_unexpected", 32'(ov0), 32'd0);
            else begin
               chk("q0_xor", 32'(q0[1:0] ^ q0[3:2]), 32'(exp0_q.pop_front()));
               chk("lat0", 32'(ecnt - t0_q.pop_front()), 32'd1);
            end
         end
         if (ov1) begin
            if (exp1_q.size() == 0) chk("ov1_unexpected", 32'(ov1), 32'd0);
            else begin
               last_exp1 = exp1_q.pop_front();
               chk("q1_xor", 32'(q1[3:0] ^ q1[7:4] ^ q1[11:8]), 32'(last_exp1));
               chk("lat1", 32'(ecnt - t1_q.pop_front()), 32'd2);
            end
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic drive0(input logic v, input logic [1:0] xa, input logic [1:0] ya,
                         input logic [1:0] e);
      logic [1:0] s, t;
      s = 2'($urandom_range(0, 3));
      t = 2'($urandom_range(0, 3));
      x0 = {xa ^ s, s};
      y0 = {ya ^ t, t};
      z0 = 2'($urandom_range(0, 3));
      v0 = v;
      exp0_in = e;
   endtask

   task automatic drive1(input logic v, input logic [3:0] xa, input logic [3:0] ya,
                         input logic [3:0] e);
      logic [3:0] s0, s1, t0, t1;
      s0 = 4'($urandom_range(0, 15));
      s1 = 4'($urandom_range(0, 15));
      t0 = 4'($urandom_range(0, 15));
      t1 = 4'($urandom_range(0, 15));
      x1 = {xa ^ s0 ^ s1, s1, s0};
      y1 = {ya ^ t0 ^ t1, t1, t0};
      z1 = 12'($urandom_range(0, 4095));
      v1 = v;
      exp1_in = e;
   endtask

   task automatic drain();
      for (int c = 0; c < 20; c++) begin
         if (exp0_q.size() == 0 && exp1_q.size() == 0) break;
         @(negedge clk);
      end
      if (exp0_q.size() != 0) chk("drain0", 32'(exp0_q.size()), 32'd0);
      if (exp1_q.size() != 0) chk("drain1", 32'(exp1_q.size()), 32'd0);
      exp0_q.delete(); t0_q.delete();
      exp1_q.delete(); t1_q.delete();
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [3:0] x;
      logic [3:0] y;
      logic [3:0] exp;
   } vec_t;
   vec_t vecs[12];

   localparam logic [11:0] XS = 12'h3A5;
   localparam logic [11:0] YS = 12'hC17;
   localparam logic [11:0] ZA = 12'h421;
   localparam logic [11:0] ZB = 12'h921;

   initial begin
      logic [7:0] r;
      logic [7:0] r0;

      // GF(16) mod x^4+x+1, computed by hand
      vecs[0]  = '{4'h0, 4'h5, 4'h0};
      vecs[1]  = '{4'h1, 4'h7, 4'h7};
      vecs[2]  = '{4'h2, 4'h2, 4'h4};
      vecs[3]  = '{4'h2, 4'h8, 4'h3};
      vecs[4]  = '{4'h3, 4'h3, 4'h5};
      vecs[5]  = '{4'h8, 4'h8, 4'hC};
      vecs[6]  = '{4'hF, 4'hF, 4'hA};
      vecs[7]  = '{4'h4, 4'h4, 4'h3};
      vecs[8]  = '{4'h9, 4'h2, 4'h1};
      vecs[9]  = '{4'hE, 4'h9, 4'h7};
      vecs[10] = '{4'h5, 4'hA, 4'h4};
      vecs[11] = '{4'hD, 4'hB, 4'h6};

      rst_n = 1'b1; en = 1'b1;
      v0 = 0; x0 = '0; y0 = '0; z0 = '0; exp0_in = '0;
      v1 = 0; x1 = '0; y1 = '0; z1 = '0; exp1_in = '0;

      // reset state
      #2 rst_n = 1'b0;
      #1;
      chk("rst_q0", 32'(q0), 32'd0);   chk("rst_ov0", 32'(ov0), 32'd0); chk("rst_b0", 32'(b0), 32'd0);
      chk("rst_q1", 32'(q1), 32'd0);   chk("rst_ov1", 32'(ov1), 32'd0); chk("rst_b1", 32'(b1), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      // X shares (3,3) encode zero; result appears one enabled cycle later
      x0 = {2'd3, 2'd3}; y0 = 4'($urandom_range(0, 15)); z0 = 2'($urandom_range(0, 3));
      v0 = 1'b1; exp0_in = 2'd0;
      @(negedge clk);
      v0 = 1'b0;
      chk("t1_ov0", 32'(ov0), 32'd1);
      chk("t1_xor0", 32'(q0[1:0] ^ q0[3:2]), 32'd0);
      @(negedge clk);
      chk("t1_ov0_drop", 32'(ov0), 32'd0);

      // GF(4) mod x^2+x+1, by hand
      drive0(1'b1, 2'd2, 2'd3, 2'd1); @(negedge clk);
      drive0(1'b1, 2'd3, 2'd3, 2'd2); @(negedge clk);
      drive0(1'b1, 2'd1, 2'd2, 2'd2); @(negedge clk);
      v0 = 1'b0;
      drain();

      // table vectors back to back on the 3-share instance
      for (int k = 0; k < 12; k++) begin
         if (k > 0) chk("busy_stream", 32'(b1), 32'd1);
         drive1(1'b1, vecs[k].x, vecs[k].y, vecs[k].exp);
         @(negedge clk);
      end
      v1 = 1'b0;
      chk("busy_tail", 32'(b1), 32'd1);
      drain();
      chk("idle_busy1", 32'(b1), 32'd0);
      chk("idle_ov1", 32'(ov1), 32'd0);

      // exhaustive operand sweep, both instances
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            r  = ref_mul(4, 9'h13, 8'(a), 8'(b));
            r0 = ref_mul(2, 9'h007, 8'(a % 4), 8'(b % 4));
            drive1(1'b1, 4'(a), 4'(b), r[3:0]);
            drive0(1'b1, 2'(a), 2'(b), r0[1:0]);
            @(negedge clk);
         end
      end
      v0 = 1'b0; v1 = 1'b0;
      drain();

      // stall mid-stream: outputs hold, stall-time inputs are dropped
      for (int i = 0; i < 6; i++) begin
         if (i == 3) begin
            en = 1'b0;
            for (int s = 0; s < 3; s++) begin
               drive1(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'hF);
               @(negedge clk);
               chk("stall_ov1", 32'(ov1), 32'd1);
               chk("stall_q1", 32'(q1[3:0] ^ q1[7:4] ^ q1[11:8]), 32'(last_exp1));
               chk("stall_busy1", 32'(b1), 32'd1);
            end
            en = 1'b1;
         end
         drive1(1'b1, vecs[i+4].x, vecs[i+4].y, vecs[i+4].exp);
         @(negedge clk);
      end
      v1 = 1'b0;
      drain();
      chk("post_stall_busy1", 32'(b1), 32'd0);

      // mask sensitivity: same operands, different pair-(1,2) mask
      r = ref_mul(4, 9'h13, 8'(XS[3:0] ^ XS[7:4] ^ XS[11:8]), 8'(YS[3:0] ^ YS[7:4] ^ YS[11:8]));
      x1 = XS; y1 = YS; z1 = ZA; v1 = 1'b1; exp1_in = r[3:0];
      @(negedge clk);
      v1 = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++)
         chk($sformatf("zA_share%0d", i), 32'(q1[i*4 +: 4]), 32'(exp_share1(i, XS, YS, ZA)));
      x1 = XS; y1 = YS; z1 = ZB; v1 = 1'b1; exp1_in = r[3:0];
      @(negedge clk);
      v1 = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++)
         chk($sformatf("zB_share%0d", i), 32'(q1[i*4 +: 4]), 32'(exp_share1(i, XS, YS, ZB)));
      drain();

      // asynchronous reset with two items in flight
      drive1(1'b1, 4'h3, 4'h3, 4'h5); @(negedge clk);
      drive1(1'b1, 4'h8, 4'h8, 4'hC); @(negedge clk);
      v1 = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_q1", 32'(q1), 32'd0);
      chk("mid_rst_ov1", 32'(ov1), 32'd0);
      chk("mid_rst_b1", 32'(b1), 32'd0);
      chk("mid_rst_q0", 32'(q0), 32'd0);
      exp0_q.delete(); t0_q.delete();
      exp1_q.delete(); t1_q.delete();
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("post_rst_b1", 32'(b1), 32'd0);
      chk("post_rst_ov1", 32'(ov1), 32'd0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
